display_scan_controller: RTL and testbench

- Multiplexes the 4-digit common-anode 7-segment display on the Basys 3.
- Driven by the 120 Hz scan strobe from the prescaler: each rising edge of the strobe advances to the next digit.
- Inserts a programmable all-off dead time between digits to suppress ghosting.
- Latches the displayed value once per frame so a digit set never tears mid-scan.
- Decodes hex to segments, with optional leading-zero suppression.

---
 rtl/display_scan_controller.sv | 142 ++++++++++++++
 tb/tb_display_scan_controller.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_controller.sv
// Four-digit common-anode 7-segment scanner for the Basys 3: strobe-driven digit
// advance, blanking dead time between digits, per-frame shadow latch, hex decode.
module display_scan_controller #(
  parameter int unsigned DEAD_CYCLES = 100,
  parameter int unsigned DEAD_W      = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clk_120Hz,
  input  logic        i_enable,
  input  logic [15:0] i_digits,
  input  logic [3:0]  i_dp,
  input  logic        i_lz_en,
  output logic [3:0]  o_an,
  output logic [6:0]  o_seg,
  output logic        o_dp,
  output logic [1:0]  o_digit_idx,
  output logic        o_frame
);

  localparam logic [1:0] S_OFF  = 2'd0;
  localparam logic [1:0] S_DEAD = 2'd1;
  localparam logic [1:0] S_ON   = 2'd2;

  localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_CYCLES);

  logic [1:0]        state;
  logic [1:0]        idx;
  logic [DEAD_W-1:0] dead_cnt;
  logic [15:0]       shadow_digits;
  logic [3:0]        shadow_dp;
  logic              shadow_lz;
  logic              tick_q;
  logic              tick_rise;
  logic              latch;
  logic [3:0]        supp;
  logic [3:0]        cur_digit;
  logic              lit;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0:    hex_to_seg = 7'b1000000;
      4'h1:    hex_to_seg = 7'b1111001;
      4'h2:    hex_to_seg = 7'b0100100;
      4'h3:    hex_to_seg = 7'b0110000;
      4'h4:    hex_to_seg = 7'b0011001;
      4'h5:    hex_to_seg = 7'b0010010;
      4'h6:    hex_to_seg = 7'b0000010;
      4'h7:    hex_to_seg = 7'b1111000;
      4'h8:    hex_to_seg = 7'b0000000;
      4'h9:    hex_to_seg = 7'b0010000;
      4'hA:    hex_to_seg = 7'b0001000;
      4'hB:    hex_to_seg = 7'b0000011;
      4'hC:    hex_to_seg = 7'b1000110;
      4'hD:    hex_to_seg = 7'b0100001;
      4'hE:    hex_to_seg = 7'b0000110;
      default: hex_to_seg = 7'b0001110;
    endcase
  endfunction

  assign tick_rise = i_clk_120Hz & ~tick_q;

  // A new frame value is captured when scanning starts or when idx wraps back to 0.
  assign latch = i_enable &&
                 ((state == S_OFF) || ((state == S_ON) && tick_rise && (idx == 2'd3)));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= S_OFF;
      idx      <= 2'd0;
      dead_cnt <= '0;
      tick_q   <= 1'b0;
    end else begin
      tick_q <= i_clk_120Hz;
      if (!i_enable) begin
        state <= S_OFF;
      end else begin
        case (state)
          S_OFF: begin
            idx      <= 2'd0;
            dead_cnt <= DEAD_LOAD;
            state    <= S_DEAD;
          end
          S_DEAD: begin
            if (dead_cnt == '0) state <= S_ON;
            else                dead_cnt <= dead_cnt - 1'b1;
          end
          S_ON: begin
            if (tick_rise) begin
              idx      <= idx + 2'd1;
              dead_cnt <= DEAD_LOAD;
              state    <= S_DEAD;
            end
          end
          default: state <= S_OFF;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      shadow_digits <= 16'h0000;
      shadow_dp     <= 4'h0;
      shadow_lz     <= 1'b0;
      o_frame       <= 1'b0;
    end else begin
      o_frame <= latch;
      if (latch) begin
        shadow_digits <= i_digits;
        shadow_dp     <= i_dp;
        shadow_lz     <= i_lz_en;
      end
    end
  end

  // A digit is blank-suppressed only while it and every digit to its left are zero with no dp.
  always_comb begin
    supp    = 4'b0000;
    supp[3] = shadow_lz && (shadow_digits[15:12] == 4'h0) && !shadow_dp[3];
    supp[2] = supp[3]   && (shadow_digits[11:8]  == 4'h0) && !shadow_dp[2];
    supp[1] = supp[2]   && (shadow_digits[7:4]   == 4'h0) && !shadow_dp[1];
  end

  assign cur_digit = shadow_digits[{idx, 2'b00} +: 4];
  assign lit       = (state == S_ON) && !supp[idx];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_an        <= 4'b1111;
      o_seg       <= 7'b1111111;
      o_dp        <= 1'b1;
      o_digit_idx <= 2'd0;
    end else begin
      o_an        <= lit ? ~(4'b0001 << idx) : 4'b1111;
      o_seg       <= lit ? hex_to_seg(cur_digit) : 7'b1111111;
      o_dp        <= lit ? ~shadow_dp[idx] : 1'b1;
      o_digit_idx <= idx;
    end
  end

endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller: two instances (dead time 3 and 0) driven by
// directed and random stimulus, compared every cycle against a behavioural model.
module tb_display_scan_controller;

  localparam int DC_A = 3;
  localparam int DC_B = 0;
  localparam int M_OFF = 0, M_BLANK = 1, M_LIT = 2;
  localparam logic [6:0] SEG_TAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        strobe = 1'b0;
  logic        en = 1'b0;
  logic        lz = 1'b0;
  logic [15:0] digits = 16'h0;
  logic [3:0]  dp = 4'h0;

  logic [3:0] an_a, an_b;
  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b;
  logic [1:0] idx_a, idx_b;
  logic       frame_a, frame_b;

  int n_cmp = 0;
  int n_bad = 0;
  bit check_on = 1'b0;

  display_scan_controller #(.DEAD_CYCLES(DC_A), .DEAD_W(8)) dut_a (
    .i_clk(clk), .i_reset(rst), .i_clk_120Hz(strobe), .i_enable(en),
    .i_digits(digits), .i_dp(dp), .i_lz_en(lz),
    .o_an(an_a), .o_seg(seg_a), .o_dp(dp_a), .o_digit_idx(idx_a), .o_frame(frame_a));

  display_scan_controller #(.DEAD_CYCLES(DC_B), .DEAD_W(8)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_clk_120Hz(strobe), .i_enable(en),
    .i_digits(digits), .i_dp(dp), .i_lz_en(lz),
    .o_an(an_b), .o_seg(seg_b), .o_dp(dp_b), .o_digit_idx(idx_b), .o_frame(frame_b));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Reference model: a slot is DC+1 blank cycles followed by the lit digit until a strobe rise.
  int m_mode[2], m_dwell[2], m_pos[2], m_val[2], m_dpv[2], m_lz[2], m_prev[2];
  int e_an[2], e_seg[2], e_dp[2], e_idx[2], e_frame[2];

  function automatic bit suppressed(int val, int dpv, int lzv, int pos);
    if (lzv == 0 || pos == 0) return 1'b0;
    return ((val >> (4 * pos)) == 0) && ((dpv >> pos) == 0);
  endfunction

  always @(posedge clk or posedge rst) begin
    bit rise_m, lit_m;
    int dc;
    for (int k = 0; k < 2; k++) begin
      dc = (k == 0) ? DC_A : DC_B;
      if (rst) begin
        m_mode[k] = M_OFF; m_dwell[k] = 0; m_pos[k] = 0;
        m_val[k] = 0; m_dpv[k] = 0; m_lz[k] = 0; m_prev[k] = 0;
        e_an[k] = 15; e_seg[k] = 127; e_dp[k] = 1; e_idx[k] = 0; e_frame[k] = 0;
      end else begin
        lit_m = (m_mode[k] == M_LIT) && !suppressed(m_val[k], m_dpv[k], m_lz[k], m_pos[k]);
        e_an[k]    = lit_m ? (15 ^ (1 << m_pos[k])) : 15;
        e_seg[k]   = lit_m ? int'(SEG_TAB[(m_val[k] >> (4 * m_pos[k])) & 15]) : 127;
        e_dp[k]    = lit_m ? 1 - ((m_dpv[k] >> m_pos[k]) & 1) : 1;
        e_idx[k]   = m_pos[k];
        e_frame[k] = 0;
        rise_m = strobe && (m_prev[k] == 0);
        m_prev[k] = int'(strobe);
        if (!en) begin
          m_mode[k] = M_OFF;
        end else if (m_mode[k] == M_OFF) begin
          m_pos[k] = 0;
          m_val[k] = int'(digits); m_dpv[k] = int'(dp); m_lz[k] = int'(lz);
          e_frame[k] = 1;
          m_dwell[k] = 0; m_mode[k] = M_BLANK;
        end else if (m_mode[k] == M_BLANK) begin
          m_dwell[k]++;
          if (m_dwell[k] == dc + 1) m_mode[k] = M_LIT;
        end else if (rise_m) begin
          m_pos[k] = (m_pos[k] + 1) % 4;
          if (m_pos[k] == 0) begin
            m_val[k] = int'(digits); m_dpv[k] = int'(dp); m_lz[k] = int'(lz);
            e_frame[k] = 1;
          end
          m_dwell[k] = 0; m_mode[k] = M_BLANK;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (check_on) begin
      chk("an_a", 32'(an_a), 32'(e_an[0]));
      chk("seg_a", 32'(seg_a), 32'(e_seg[0]));
      chk("dp_a", 32'(dp_a), 32'(e_dp[0]));
      chk("idx_a", 32'(idx_a), 32'(e_idx[0]));
      chk("frame_a", 32'(frame_a), 32'(e_frame[0]));
      chk("an_b", 32'(an_b), 32'(e_an[1]));
      chk("seg_b", 32'(seg_b), 32'(e_seg[1]));
      chk("dp_b", 32'(dp_b), 32'(e_dp[1]));
      chk("idx_b", 32'(idx_b), 32'(e_idx[1]));
      chk("frame_b", 32'(frame_b), 32'(e_frame[1]));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int hi, input int lo);
    strobe = 1'b1; cyc(hi);
    strobe = 1'b0; cyc(lo);
  endtask

  function automatic logic [15:0] rand_digits();
    logic [15:0] d;
    d = 16'h0;
    for (int i = 0; i < 4; i++)
      d = {d[11:0], ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15))};
    return d;
  endfunction

  initial begin
    int waited, hi_left, lo_left, off_left;
    #2 rst = 1'b1;
    #1;
    chk("reset_an", 32'(an_a), 32'hF);
    chk("reset_seg", 32'(seg_a), 32'h7F);
    chk("reset_dp", 32'(dp_a), 32'h1);
    chk("reset_idx", 32'(idx_a), 32'h0);
    chk("reset_frame", 32'(frame_a), 32'h0);
    check_on = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(2);

    // scan order, then tear-free relatch mid-frame
    digits = 16'h1234; en = 1'b1;
    cyc(8);
    pulse(1, 10);
    digits = 16'hABCD;
    repeat (6) pulse(1, 10);

    // leading-zero suppression, without and with a dp on digit 2
    digits = 16'h0070; lz = 1'b1;
    repeat (8) pulse(2, 9);
    dp = 4'b0100;
    repeat (8) pulse(2, 9);
    dp = 4'b0000; lz = 1'b0; digits = 16'h5A0F;

    // strobe edges inside the dead time, and a strobe held high
    repeat (6) pulse(1, 1);
    cyc(10);
    strobe = 1'b1; cyc(30); strobe = 1'b0; cyc(10);

    // enable dropped on the cycle the dead counter of dut_a expires
    strobe = 1'b1; cyc(4);
    en = 1'b0; strobe = 1'b0; cyc(5);
    en = 1'b1; cyc(12);
    repeat (3) pulse(1, 8);

    // asynchronous reset while digit 2 is lit
    en = 1'b0; cyc(2);
    digits = 16'h1234; lz = 1'b0; en = 1'b1; cyc(8);
    pulse(1, 10);
    strobe = 1'b1; cyc(1); strobe = 1'b0;
    waited = 0;
    while (an_a !== 4'b1011 && waited < 50) begin
      cyc(1); waited++;
    end
    chk("wait_digit2", 32'(an_a), 32'hB);
    @(posedge clk); #2 rst = 1'b1; #1;
    chk("async_an", 32'(an_a), 32'hF);
    chk("async_seg", 32'(seg_a), 32'h7F);
    chk("async_dp", 32'(dp_a), 32'h1);
    @(negedge clk); rst = 1'b0;
    cyc(12);

    // randomized operation
    hi_left = 0; lo_left = 5; off_left = 0;
    for (int c = 0; c < 4000; c++) begin
      if (strobe) begin
        hi_left--;
        if (hi_left <= 0) begin strobe = 1'b0; lo_left = $urandom_range(1, 14); end
      end else begin
        lo_left--;
        if (lo_left <= 0) begin strobe = 1'b1; hi_left = $urandom_range(1, 5); end
      end
      if (en && $urandom_range(0, 299) == 0) begin
        en = 1'b0; off_left = $urandom_range(1, 15);
      end else if (!en) begin
        off_left--;
        if (off_left <= 0) en = 1'b1;
      end
      if ($urandom_range(0, 49) == 0) digits = rand_digits();
      if ($urandom_range(0, 49) == 0) dp = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) lz = 1'($urandom_range(0, 1));
      cyc(1);
    end

    cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
